// File: rtl/bouncing_sprites.sv
// bouncing_sprites: VGA raster engine drawing NSPRITES bouncing squares with a per-frame collision flag
module bouncing_sprites #(
   parameter int          NSPRITES  = 2,
   parameter int          OUT_BITS  = 6,
   parameter int          SPR_SIZE  = 16,
   parameter logic [95:0] SPR_RGB   = {24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000},
   parameter logic [23:0] BG_RGB    = 24'h000040,
   parameter int          H_ACTIVE  = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_ACTIVE  = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0,
   parameter logic [39:0] INIT_X    = {10'd224, 10'd160, 10'd96, 10'd32},
   parameter logic [39:0] INIT_Y    = {10'd160, 10'd112, 10'd64, 10'd16}
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pause,
   output logic [OUT_BITS-1:0] r,
   output logic [OUT_BITS-1:0] g,
   output logic [OUT_BITS-1:0] b,
   output logic                hsync,
   output logic                vsync,
   output logic                frame_start,
   output logic                collide
);
   localparam int         H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int         V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] X_MAX   = 10'(H_ACTIVE - SPR_SIZE);
   localparam logic [9:0] Y_MAX   = 10'(V_ACTIVE - SPR_SIZE);

   logic [9:0]          h_q, h_d, v_q, v_d;
   logic [9:0]          x_q [NSPRITES];
   logic [9:0]          x_d [NSPRITES];
   logic [9:0]          y_q [NSPRITES];
   logic [9:0]          y_d [NSPRITES];
   logic [NSPRITES-1:0] dx_q, dx_d, dy_q, dy_d;
   logic                sticky_q, sticky_d;
   logic [OUT_BITS-1:0] r_q, g_q, b_q;
   logic                hs_q, vs_q, fs_q, col_q;
   logic [NSPRITES-1:0] hit;
   logic                active, upd, overlap, hs_on, vs_on;
   logic [23:0]         pix;

   // raster counters: h wraps each line, v advances on h wrap
   always_comb begin
      h_d = (h_q == 10'(H_TOTAL - 1)) ? '0 : h_q + 10'd1;
      v_d = (h_q != 10'(H_TOTAL - 1)) ? v_q : (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
      upd = (h_q == '0) && (v_q == 10'(V_ACTIVE));
      active = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
      hs_on = (h_q >= 10'(H_ACTIVE + H_FP)) && (h_q < 10'(H_ACTIVE + H_FP + H_SYNC));
      vs_on = (v_q >= 10'(V_ACTIVE + V_FP)) && (v_q < 10'(V_ACTIVE + V_FP + V_SYNC));
   end

   // hit test and colour mux; the lowest-index covering sprite wins
   always_comb begin
      hit = '0;
      for (int i = 0; i < NSPRITES; i++)
         hit[i] = (h_q >= x_q[i]) && ({1'b0, h_q} < {1'b0, x_q[i]} + 11'(SPR_SIZE)) &&
                  (v_q >= y_q[i]) && ({1'b0, v_q} < {1'b0, y_q[i]} + 11'(SPR_SIZE));
      pix = BG_RGB;
      for (int i = NSPRITES - 1; i >= 0; i--)
         if (hit[i]) pix = SPR_RGB[24*i +: 24];
      if (!active) pix = '0;
      overlap = active && ((hit & (hit - NSPRITES'(1))) != '0);
      sticky_d = upd ? 1'b0 : sticky_q | overlap;
   end

   // candidate next positions: reverse at an edge, then step one pixel in the new direction
   always_comb begin
      for (int i = 0; i < NSPRITES; i++) begin
         dx_d[i] = (dx_q[i] && x_q[i] == X_MAX) ? 1'b0 : (!dx_q[i] && x_q[i] == '0) ? 1'b1 : dx_q[i];
         dy_d[i] = (dy_q[i] && y_q[i] == Y_MAX) ? 1'b0 : (!dy_q[i] && y_q[i] == '0) ? 1'b1 : dy_q[i];
         x_d[i] = dx_d[i] ? x_q[i] + 10'd1 : x_q[i] - 10'd1;
         y_d[i] = dy_d[i] ? y_q[i] + 10'd1 : y_q[i] - 10'd1;
      end
   end

   // counters, sprite state and sticky overlap bit; motion only on an unpaused update cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         h_q <= '0;
         v_q <= '0;
         sticky_q <= 1'b0;
         for (int i = 0; i < NSPRITES; i++) begin
            x_q[i] <= INIT_X[10*i +: 10];
            y_q[i] <= INIT_Y[10*i +: 10];
            dx_q[i] <= (i % 2 == 0);
            dy_q[i] <= 1'b1;
         end
      end else begin
         h_q <= h_d;
         v_q <= v_d;
         sticky_q <= sticky_d;
         if (upd && !pause) begin
            x_q <= x_d;
            y_q <= y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
         end
      end

   // registered pin stage: colour MSBs, syncs, frame pulse and last frame's collision
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_q <= '0;
         g_q <= '0;
         b_q <= '0;
         hs_q <= ~HSYNC_POL;
         vs_q <= ~VSYNC_POL;
         fs_q <= 1'b0;
         col_q <= 1'b0;
      end else begin
         r_q <= pix[23 -: OUT_BITS];
         g_q <= pix[15 -: OUT_BITS];
         b_q <= pix[7 -: OUT_BITS];
         hs_q <= hs_on ? HSYNC_POL : ~HSYNC_POL;
         vs_q <= vs_on ? VSYNC_POL : ~VSYNC_POL;
         fs_q <= upd;
         if (upd) col_q <= sticky_q;
      end

   assign r = r_q;
   assign g = g_q;
   assign b = b_q;
   assign hsync = hs_q;
   assign vsync = vs_q;
   assign frame_start = fs_q;
   assign collide = col_q;
endmodule

// File: tb/tb_bouncing_sprites.sv
// tb_bouncing_sprites: table vectors plus a frame-level reference model for bouncing_sprites
module tb_bouncing_sprites;
   localparam int NS = 2, SZ = 8;
   localparam int HA = 40, HFP = 4, HSY = 8, HBP = 4, HT = HA + HFP + HSY + HBP;
   localparam int VA = 30, VFP = 2, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
   localparam int FR = HT * VT;
   localparam logic [21:0] RST_V = {18'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   logic clk, rst_n, pause;
   logic [5:0] r, g, b;
   logic hsync, vsync, frame_start, collide;
   logic [21:0] outv;
   assign outv = {r, g, b, hsync, vsync, frame_start, collide};

   bouncing_sprites #(
      .NSPRITES(NS), .OUT_BITS(6), .SPR_SIZE(SZ),
      .SPR_RGB({24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000}), .BG_RGB(24'h000040),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
      .INIT_X({10'd0, 10'd0, 10'd24, 10'd28}), .INIT_Y({10'd0, 10'd0, 10'd8, 10'd4})
   ) dut (
      .clk(clk), .rst_n(rst_n), .pause(pause), .r(r), .g(g), .b(b),
      .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .collide(collide)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int h;
      int v;
      logic [5:0] r, g, b;
      logic hs, vs, fs, col;
      string nm;
   } vec_t;
   vec_t tbl[$];

   int n, n_cmp, n_bad;
   int mx[NS], my[NS];
   bit mdx[NS], mdy[NS];
   bit msticky, mcol;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (index %0d)", nm, got, exp, n);
      end
   endtask

   task automatic add(input int h, input int v, input logic [5:0] rr, input logic [5:0] gg,
                      input logic [5:0] bb, input logic hs, input logic vs, input logic fs,
                      input logic col, input string nm);
      vec_t e;
      e.h = h; e.v = v; e.r = rr; e.g = gg; e.b = bb;
      e.hs = hs; e.vs = vs; e.fs = fs; e.col = col; e.nm = nm;
      tbl.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic model_reset();
      mx[0] = 28; my[0] = 4; mdx[0] = 1; mdy[0] = 1;
      mx[1] = 24; my[1] = 8; mdx[1] = 0; mdy[1] = 1;
      msticky = 0;
      mcol = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("async_reset", outv, RST_V);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_hold", outv, RST_V);
      rst_n = 1'b1;
      n = -1;
      model_reset();
   endtask

   function automatic bit covers(int k, int h, int v);
      return mx[k] <= h && h < mx[k] + SZ && my[k] <= v && v < my[k] + SZ;
   endfunction

   function automatic int ncover(int h, int v);
      int c;
      c = 0;
      for (int k = 0; k < NS; k++) if (covers(k, h, v)) c++;
      return c;
   endfunction

   function automatic logic [21:0] expv(int h, int v);
      logic [23:0] c;
      bit found;
      c = 24'h0;
      found = 0;
      if (h < HA && v < VA) begin
         c = 24'h000040;
         for (int k = 0; k < NS; k++)
            if (!found && covers(k, h, v)) begin
               c = (k == 0) ? 24'hFF0000 : 24'h00FF00;
               found = 1;
            end
      end
      return {c[23:18], c[15:10], c[7:2], !(h >= HA + HFP && h < HA + HFP + HSY),
              !(v >= VA + VFP && v < VA + VFP + VSY), (h == 0 && v == VA), mcol};
   endfunction

   task automatic axis(input int p, input bit d, input int lim, output int po, output bit dout);
      if (d && p == lim) begin dout = 0; po = p - 1; end
      else if (!d && p == 0) begin dout = 1; po = 1; end
      else begin dout = d; po = d ? p + 1 : p - 1; end
   endtask

   task automatic step_model(input bit p);
      int h, v, np;
      bit nd;
      tick();
      h = n % HT;
      v = (n / HT) % VT;
      if (h == 0 && v == VA) begin
         mcol = msticky;
         msticky = 0;
      end else if (h < HA && v < VA && ncover(h, v) >= 2) msticky = 1;
      chk("raster", outv, expv(h, v));
      if (h == 0 && v == VA && !p)
         for (int k = 0; k < NS; k++) begin
            axis(mx[k], mdx[k], HA - SZ, np, nd);
            mx[k] = np; mdx[k] = nd;
            axis(my[k], mdy[k], VA - SZ, np, nd);
            my[k] = np; mdy[k] = nd;
         end
   endtask

   initial begin
      int w, cnt;
      n_cmp = 0;
      n_bad = 0;
      n = -1;
      rst_n = 1'b1;
      pause = 1'b0;
      add(0, 1, 0, 0, 16, 1, 1, 0, 0, "bg");
      add(39, 1, 0, 0, 16, 1, 1, 0, 0, "bg_last_active");
      add(40, 1, 0, 0, 0, 1, 1, 0, 0, "h_blank");
      add(28, 4, 63, 0, 0, 1, 1, 0, 0, "spr0_origin");
      add(36, 4, 0, 0, 16, 1, 1, 0, 0, "spr0_right_out");
      add(24, 8, 0, 63, 0, 1, 1, 0, 0, "spr1_origin");
      add(30, 10, 63, 0, 0, 1, 1, 0, 0, "overlap_priority");
      add(35, 11, 63, 0, 0, 1, 1, 0, 0, "spr0_corner");
      add(31, 15, 0, 63, 0, 1, 1, 0, 0, "spr1_corner");
      add(24, 16, 0, 0, 16, 1, 1, 0, 0, "spr1_below");
      add(44, 20, 0, 0, 0, 0, 1, 0, 0, "hsync_on");
      add(51, 20, 0, 0, 0, 0, 1, 0, 0, "hsync_last");
      add(52, 20, 0, 0, 0, 1, 1, 0, 0, "hsync_off");
      add(0, 30, 0, 0, 0, 1, 1, 1, 1, "update_collide");
      add(0, 32, 0, 0, 0, 1, 0, 0, 1, "vsync_on");
      add(5, 33, 0, 0, 0, 1, 0, 0, 1, "vsync_last");
      add(0, 34, 0, 0, 0, 1, 1, 0, 1, "vsync_off");
      #2;
      do_reset();
      for (int k = 0; k < 200 && hsync !== 1'b0; k++) tick();
      chk("hsync_first_low", n, HA + HFP);
      w = 0;
      while (hsync === 1'b0 && w < 100) begin
         tick();
         w++;
      end
      chk("hsync_width", w, HSY);
      foreach (tbl[i]) begin
         while (n < tbl[i].v * HT + tbl[i].h) tick();
         chk(tbl[i].nm, outv, {tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].col});
      end
      do_reset();
      for (int k = 0; k < 20 * FR; k++) begin
         pause = ($urandom_range(0, 7) == 0);
         step_model(pause);
      end
      pause = 1'b1;
      cnt = 0;
      for (int k = 0; k < 3 * FR; k++) begin
         step_model(pause);
         cnt += int'(frame_start);
      end
      chk("pause_frame_pulses", cnt, 3);
      pause = 1'b0;
      for (int k = 0; k < FR; k++) step_model(pause);
      for (int k = 0; k < 2 * FR && !(n % HT == 20 && (n / HT) % VT == 15); k++) step_model(pause);
      chk("midline_reached", n % HT + 100 * ((n / HT) % VT), 1520);
      do_reset();
      for (int k = 0; k < 2 * FR; k++) step_model(pause);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
